muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: FSM states, funct3
// encodings and operand-signedness decode.
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   function automatic logic a_is_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f);
      return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; with neg_i = sign bit it yields the
// magnitude, with neg_i = result sign it restores a signed result.
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, followed by one sign-fix cycle. Fixed WIDTH+2 latency.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int XLEN_CNT = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t                state_q, state_d;
   logic [XLEN_CNT-1:0]   cnt_q, cnt_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [WIDTH-1:0]      hi_q, hi_d;
   logic [WIDTH-1:0]      lo_q, lo_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic                  sign_a_q, sign_a_d;
   logic                  sign_b_q, sign_b_d;
   logic                  div_zero_q, div_zero_d;

   logic [WIDTH-1:0]      abs_a, abs_b;
   logic                  neg_a_in, neg_b_in;
   logic [WIDTH:0]        add_sum, rem_shift, rem_diff;
   logic                  rem_ge;
   logic [2*WIDTH-1:0]    fix_in, fix_out;
   logic                  fix_neg;
   logic [WIDTH-1:0]      fix_result;

   assign neg_a_in = a_is_signed(funct3) & op_a[WIDTH-1];
   assign neg_b_in = b_is_signed(funct3) & op_b[WIDTH-1];

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.val_i(op_a), .neg_i(neg_a_in), .val_o(abs_a));
   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.val_i(op_b), .neg_i(neg_b_in), .val_o(abs_b));

   // hi:lo is the product shift pair for MUL*, remainder:dividend/quotient for DIV*
   assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
   assign rem_shift = {hi_q, lo_q[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, b_q};
   assign rem_ge    = (rem_shift >= {1'b0, b_q});

   always_comb begin
      fix_in  = {hi_q, lo_q};
      fix_neg = sign_a_q ^ sign_b_q;
      if (funct3_q[2]) begin
         if (funct3_q[1]) begin
            fix_in  = {{WIDTH{1'b0}}, hi_q};
            fix_neg = sign_a_q;
         end else begin
            fix_in  = {{WIDTH{1'b0}}, lo_q};
         end
      end
   end

   muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix (.val_i(fix_in), .neg_i(fix_neg), .val_o(fix_out));

   // Signed overflow needs no special path: |min|/1 = min with a positive sign,
   // and a zero divisor leaves the dividend magnitude in the remainder.
   always_comb begin
      fix_result = fix_out[WIDTH-1:0];
      case (funct3_q)
         F3_MULH, F3_MULHSU, F3_MULHU: fix_result = fix_out[2*WIDTH-1:WIDTH];
         F3_DIV, F3_DIVU:              if (div_zero_q) fix_result = {WIDTH{1'b1}};
         default:                      fix_result = fix_out[WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      funct3_d   = funct3_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      b_d        = b_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      div_zero_d = div_zero_q;
      result_d   = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               funct3_d   = funct3;
               hi_d       = '0;
               lo_d       = abs_a;
               b_d        = abs_b;
               sign_a_d   = neg_a_in;
               sign_b_d   = neg_b_in;
               div_zero_d = (op_b == '0);
               cnt_d      = '0;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            // The counter runs to WIDTH; the cycle at WIDTH only hands over to FIX.
            if (cnt_q == XLEN_CNT'(WIDTH)) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q + XLEN_CNT'(1);
               if (!funct3_q[2]) begin
                  hi_d = add_sum[WIDTH:1];
                  lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
               end else begin
                  hi_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], rem_ge};
               end
            end
         end
         ST_FIX: begin
            result_d = fix_result;
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         funct3_q   <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         funct3_q   <= funct3_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         b_q        <= b_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         div_zero_q <= div_zero_d;
         result_q   <= result_d;
      end
   end

   assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign stall  = busy || ((state_q == ST_IDLE) && start && !flush);
   assign done   = (state_q == ST_DONE) && !flush;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with an arithmetic reference model and a
// per-cycle checker of busy/stall/done/result.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int LAT = 34;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, stall, done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .flush(flush),
      .busy(busy), .stall(stall), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      r  = '0;
      case (f)
         F3_MUL:    begin p = sa * sb; r = p[31:0];  end
         F3_MULH:   begin p = sa * sb; r = p[63:32]; end
         F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
         F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
         F3_DIV: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         F3_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Model: age = edges since the accepting edge, -1 when idle
   int          age = -1;
   logic [31:0] pend = '0;
   logic [31:0] exp_res = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         age     <= -1;
         exp_res <= '0;
      end else if (flush) begin
         age <= -1;
      end else if (age < 0) begin
         if (start) begin
            age  <= 0;
            pend <= ref_result(funct3, op_a, op_b);
         end
      end else if (age == LAT) begin
         age <= -1;
      end else begin
         age <= age + 1;
         if (age == LAT - 1) exp_res <= pend;
      end
   end

   always @(negedge clk) begin
      check("busy",   32'(busy),   32'((age >= 0) && (age < LAT)));
      check("done",   32'(done),   32'((age == LAT) && !flush));
      check("stall",  32'(stall),  32'(((age >= 0) && (age < LAT)) || ((age < 0) && start && !flush)));
      check("result", result, exp_res);
   end

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lit;
      bit          poke;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] lit, input bit poke);
      vec_t v;
      v.f = f; v.a = a; v.b = b; v.lit = lit; v.poke = poke;
      vecs.push_back(v);
   endtask

   // Called with the DUT in IDLE; returns one edge after DONE, back in IDLE.
   task automatic run_op(input vec_t v);
      int n;
      bit got;
      check("model_lit", ref_result(v.f, v.a, v.b), v.lit);
      funct3 = v.f; op_a = v.a; op_b = v.b; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < LAT + 6) begin
         @(posedge clk); #1;
         n++;
         if (v.poke && n == 5) start = 1'b1;
         if (v.poke && n == 6) start = 1'b0;
         if (done === 1'b1) got = 1'b1;
      end
      check("latency", 32'(n), 32'(LAT));
      check("result_lit", result, v.lit);
      if (v.poke) begin
         funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
   endtask

   initial begin
      bit got;
      add(F3_MUL,    32'd7,         32'd6,         32'h0000_002A, 1'b0);
      add(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      add(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      add(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
      add(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
      add(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
      add(F3_DIVU,   32'd7,         32'd2,         32'd3,         1'b0);
      add(F3_REMU,   32'd7,         32'd2,         32'd1,         1'b0);
      add(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
      add(F3_REM,    32'd5,         32'd0,         32'd5,         1'b0);
      add(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      add(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
      add(F3_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b1);
      add(F3_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
      add(F3_REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         1'b1);

      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   32'(busy), 32'd0);
      check("reset_done",   32'(done), 32'd0);
      check("reset_result", result,    32'd0);
      @(posedge clk); #2 reset = 1'b0;

      // First op goes in on the first edge after reset release
      foreach (vecs[i]) run_op(vecs[i]);

      // Flush mid-CALC: no done, result keeps the previous REM value
      funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      got = 1'b0;
      repeat (LAT + 6) begin
         @(posedge clk); #1;
         if (done === 1'b1) got = 1'b1;
      end
      check("flush_no_done", 32'(got), 32'd0);
      check("flush_result_hold", result, 32'd2);
      run_op('{F3_DIVU, 32'd1000, 32'd3, 32'h0000_014D, 1'b0});

      // Flush and start together in IDLE: flush wins
      funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 32'(busy), 32'd0);

      // Reset mid-CALC: operation abandoned, no done afterwards
      funct3 = F3_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_async_busy",   32'(busy), 32'd0);
      check("rst_async_result", result,    32'd0);
      @(posedge clk); #2 reset = 1'b0;
      got = 1'b0;
      repeat (LAT + 6) begin
         @(posedge clk); #1;
         if (done === 1'b1) got = 1'b1;
      end
      check("rst_no_done", 32'(got), 32'd0);
      run_op('{F3_MUL, 32'd7, 32'd6, 32'h0000_002A, 1'b0});

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
